mdu_execute: RTL and testbench
==============================

# mdu_execute

Iterative multiply/divide unit for the execute stage of the pipelined RV32I core. It consumes the register operands delivered by the decode→execute pipeline register and computes RV32M results over multiple cycles. While it computes, it drives a stall back to the fetch/decode/execute pipeline registers, so the M-extension instruction is held in execute until its result is ready. It uses a shift-add multiplier and a restoring divider, one bit per cycle.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- clk  input  1  core clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- StartE  input  1  execute-stage instruction is an M-extension op (decoder-qualified)
- MulDivOpE  input  3  operation, equal to instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  32  rs1 operand (after forwarding mux)
- SrcBE  input  32  rs2 operand (after forwarding mux)
- StallE  output  1  hold F/D/E pipeline registers this cycle
- DoneE  output  1  ResultE valid this cycle
- ResultE  output  32  M-extension result

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - StartE=1 with a normal op: latch the op, sign flags and absolute-value operands (unsigned ops take operands raw), clear the 5-bit counter, go to CALC.
  - StartE=1 with DIV/DIVU/REM/REMU and SrcBE=0: compute the special result directly, go to DONE.
  - StartE=1 with DIV/REM, SrcAE=0x80000000 and SrcBE=0xFFFFFFFF: compute the special result directly, go to DONE.
- CALC: one multiply or divide step per cycle; the counter counts 0..31; at count 31 go to DONE.
- DONE: DoneE=1, ResultE valid, StallE=0; the pipeline advances. Unconditionally go to IDLE. StartE is ignored because it still reflects the same instruction.
- StartE is ignored in CALC and DONE.
- Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier. Signedness per op:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, MUL: both unsigned.
  - The final product is negated when the operand signs differ.
  - MUL returns bits [31:0]; the others return bits [63:32].
- Divide: restoring, on 32-bit absolute values.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = SrcAE.
  - Signed overflow: quotient 0x80000000; remainder 0.
- Reset in any state: go to IDLE and clear all registers. StallE, DoneE and ResultE are 0 in the cycle after reset is sampled. An in-flight operation is discarded.

## Timing
- StallE = (state==IDLE & StartE) | (state==CALC). Combinational from state and StartE.
- Normal op:
  - Start accepted at cycle N.
  - CALC spans cycles N+1..N+32.
  - DONE at N+33.
  - StallE is high for cycles N..N+32 (33 cycles).
- Special-case op: StallE is high at N only; DONE at N+1.
- ResultE and DoneE are registered outputs, valid only in DONE. ResultE holds its value in IDLE but is qualified by DoneE.
- Back-to-back M ops: the second op's StartE is sampled in IDLE in the cycle after DONE. There are no lost or duplicated operations.

## Structure
- mdu_pkg:
  - XLEN.
  - enum mdu_op_e, encoded as funct3.
  - enum mdu_state_e {IDLE, CALC, DONE}.
  - Helper function abs32.
- A single module, with the FSM and datapath together. No sub-module is needed.
- The decoder and hazard unit OR StallE into their stall/enable outputs. That integration lives outside this block.

## Test plan
- MUL: SrcAE=7, SrcBE=6 → DoneE at start+33, ResultE=42, StallE high for exactly 33 cycles.
- MULH: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU on the same operands → 0xFFFFFFFE. MULHSU on the same operands → 0xFFFFFFFF.
- DIV: −7/2 → 0xFFFFFFFD. REM: −7 rem 2 → 0xFFFFFFFF. DIVU: 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU: 5/0 → 0xFFFFFFFF. REM: 5 rem 0 → 5. DIV: 0x80000000/−1 → 0x80000000. All three: DoneE at start+1, StallE high for 1 cycle.
- rst asserted at CALC cycle 10 → next cycle state IDLE, StallE=0, DoneE=0, ResultE=0. A new MUL 3×3 then returns 9 normally.
- Back-to-back MUL 2×3 then DIVU 100/7:
  - Results 6 then 14, each with a single DoneE pulse.
  - StartE held high through DONE does not retrigger.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
// Op encoding matches instruction funct3 so the decoder can pass it straight through.
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_execute.sv
// Execute-stage RV32M unit: shift-add multiplier and restoring divider, one bit per cycle,
// stalling the front of the pipeline until the result is registered.
module mdu_execute #(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);
  import mdu_pkg::*;

  mdu_state_e          r_state, w_state_nxt;
  mdu_op_e             r_op, w_op;
  logic                r_neg, r_neg_rem;
  logic [4:0]          r_cnt;
  logic [2*XLEN-1:0]   r_acc, r_mcand;
  logic [XLEN-1:0]     r_mplr;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div, w_div0, w_ovf, w_special;
  logic                w_sa, w_sb;
  logic [XLEN-1:0]     w_a_in, w_b_in, w_special_res;
  logic [2*XLEN-1:0]   w_mul_acc, w_acc_step, w_mcand_step, w_prod;
  logic [XLEN:0]       w_shift, w_diff;
  logic                w_fits;
  logic [XLEN-1:0]     w_mplr_step, w_quo, w_rem, w_calc_res;

  assign w_op     = mdu_op_e'(MulDivOpE);
  assign w_is_div = w_op[2];
  assign w_div0   = w_is_div && (SrcBE == '0);
  assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM) &&
                    (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
  assign w_special = w_div0 || w_ovf;

  // Bit 1 of a divide op selects remainder; div-by-zero takes priority over overflow.
  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = w_op[1] ? SrcAE : '1;
    else if (w_ovf)
      w_special_res = w_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  assign w_sa   = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_sb   = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_in = (w_sa && SrcAE[XLEN-1]) ? abs32(SrcAE) : SrcAE;
  assign w_b_in = (w_sb && SrcBE[XLEN-1]) ? abs32(SrcBE) : SrcBE;

  // Multiply keeps multiplicand in r_mcand and multiplier in r_mplr; divide keeps the
  // divisor in r_mcand, shifts dividend bits out of r_mplr and quotient bits into it.
  assign w_mul_acc = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_shift   = {r_acc[XLEN-1:0], r_mplr[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_mcand[XLEN-1:0]};
  assign w_fits    = ~w_diff[XLEN];

  always_comb begin
    if (r_op[2]) begin
      w_acc_step   = {{XLEN{1'b0}}, (w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0])};
      w_mplr_step  = {r_mplr[XLEN-2:0], w_fits};
      w_mcand_step = r_mcand;
    end else begin
      w_acc_step   = w_mul_acc;
      w_mplr_step  = r_mplr >> 1;
      w_mcand_step = r_mcand << 1;
    end
  end

  assign w_prod = r_neg ? -w_acc_step : w_acc_step;
  assign w_quo  = r_neg ? -w_mplr_step : w_mplr_step;
  assign w_rem  = r_neg_rem ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];

  always_comb begin
    w_calc_res = '0;
    case (r_op)
      OP_MUL:                       w_calc_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_calc_res = w_quo;
      default:                      w_calc_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (StartE) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == 5'd31) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    StallE = ((r_state == IDLE) && StartE) || (r_state == CALC);
    DoneE  = r_done;
    ResultE = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_MUL;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (StartE) begin
            r_op  <= w_op;
            r_cnt <= '0;
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
            end else begin
              r_neg     <= (w_sa & SrcAE[XLEN-1]) ^ (w_sb & SrcBE[XLEN-1]);
              r_neg_rem <= w_sa & SrcAE[XLEN-1];
              r_acc     <= '0;
              r_mcand   <= {{XLEN{1'b0}}, (w_is_div ? w_b_in : w_a_in)};
              r_mplr    <= w_is_div ? w_a_in : w_b_in;
            end
          end
        end
        CALC: begin
          r_acc   <= w_acc_step;
          r_mplr  <= w_mplr_step;
          r_mcand <= w_mcand_step;
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_calc_res;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_execute.sv
// Directed-vector bench for mdu_execute: results, latency, stall length, reset abort, back-to-back.
module tb_mdu_execute;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        StallE, DoneE;
  logic [31:0] ResultE;

  int n_checks = 0;
  int n_errors = 0;

  mdu_execute #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallE(StallE), .DoneE(DoneE), .ResultE(ResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one op from the current mid-cycle point, holds StartE through DONE,
  // then releases it in the following IDLE cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int lat;
    int stalls;
    bit seen;
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    #1;
    stalls = StallE ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (DoneE) seen = 1'b1;
      else if (StallE) stalls++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
      check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat_exp));
      check({tag, ".result"}, ResultE, exp);
      check({tag, ".stall_in_done"}, 32'(StallE), 32'd0);
    end
    @(posedge clk); #1;
    StartE = 1'b0;
    #1;
    check({tag, ".single_done"}, 32'(DoneE), 32'd0);
    check({tag, ".idle_no_stall"}, 32'(StallE), 32'd0);
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b0; MulDivOpE = 3'b000; SrcAE = '0; SrcBE = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.stall", 32'(StallE), 32'd0);
    check("reset.done", 32'(DoneE), 32'd0);
    check("reset.result", ResultE, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7x6",    3'b000, 32'd7,        32'd6,        32'd42,         33);
    run_op("mulh_m1m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,   33);
    run_op("mulhu_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33);
    run_op("mulhsu_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,   33);
    run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   33);
    run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   33);
    run_op("divu_big_2", 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,   33);
    run_op("divu_5_0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF,   1);
    run_op("rem_5_0",    3'b110, 32'd5,        32'd0,        32'd5,          1);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1);

    // Abort a multiply part-way through CALC; ResultE still holds 0x80000000 here.
    StartE = 1'b1; MulDivOpE = 3'b000; SrcAE = 32'd5; SrcBE = 32'd5;
    repeat (11) @(posedge clk);
    #1;
    check("abort.stall_before", 32'(StallE), 32'd1);
    rst = 1'b1; StartE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.stall", 32'(StallE), 32'd0);
    check("abort.done", 32'(DoneE), 32'd0);
    check("abort.result", ResultE, 32'd0);
    begin
      int late_done = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (DoneE) late_done++;
      end
      check("abort.no_late_done", 32'(late_done), 32'd0);
    end
    run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 33);

    run_op("b2b_mul_2x3",    3'b000, 32'd2,   32'd3, 32'd6,  33);
    run_op("b2b_divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
